// File: rtl/rgb_pattern_controller.sv
// RGB test-pattern generator: solid colour, colour bars, checkerboard and a
// grey fade. Mode and colour changes take effect only at frame start so a
// frame is never drawn with two different patterns.
module rgb_pattern_controller #(
    parameter int unsigned CW       = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned SQ_LOG   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              video_on,
    input  logic              p_tick,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic [3*CW-1:0]   sw,
    input  logic [1:0]        mode,
    input  logic              mode_load,
    output logic [3*CW-1:0]   rgb
);

    localparam int unsigned RGB_W = 3 * CW;
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    localparam logic [1:0] MODE_SOLID   = 2'd0;
    localparam logic [1:0] MODE_BARS    = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;
    localparam logic [1:0] MODE_FADE    = 2'd3;

    logic [1:0]       mode_pending_q, mode_pending_d;
    logic [1:0]       mode_active_q,  mode_active_d;
    logic [RGB_W-1:0] color_q,        color_d;
    logic [CW-1:0]    level_q,        level_d;
    logic [RGB_W-1:0] rgb_q,          rgb_d;

    logic             frame_start_c;
    logic [2:0]       bar_idx_c;
    logic [RGB_W-1:0] bar_rgb_c;
    logic [RGB_W-1:0] pattern_c;

    assign frame_start_c = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

    // Frame-synchronous control: pending mode, active mode, colour, fade level
    always_comb begin
        mode_pending_d = mode_pending_q;
        mode_active_d  = mode_active_q;
        color_d        = color_q;
        level_d        = level_q;
        if (mode_load) begin
            mode_pending_d = mode;
        end
        if (frame_start_c) begin
            // A load on the frame-start edge bypasses the pending register
            mode_active_d = mode_load ? mode : mode_pending_q;
            color_d       = sw;
            level_d       = level_q + CW'(1);
        end
    end

    // Bar index: smallest k with pixel_x < (k+1)*BAR_W, else 7 (off-screen clamp)
    always_comb begin
        bar_idx_c = 3'd7;
        for (int k = 7; k >= 0; k--) begin
            if (32'(pixel_x) < 32'((k + 1) * BAR_W)) begin
                bar_idx_c = 3'(k);
            end
        end
    end

    // Bar colour from the index bits: R=~i[1], G=~i[2], B=~i[0]
    always_comb begin
        bar_rgb_c = '0;
        bar_rgb_c[RGB_W-1 -: CW] = {CW{~bar_idx_c[1]}};
        bar_rgb_c[2*CW-1  -: CW] = {CW{~bar_idx_c[2]}};
        bar_rgb_c[CW-1    -: CW] = {CW{~bar_idx_c[0]}};
    end

    // Pattern select from the pre-edge mode, colour and level
    always_comb begin
        pattern_c = color_q;
        case (mode_active_q)
            MODE_SOLID:   pattern_c = color_q;
            MODE_BARS:    pattern_c = bar_rgb_c;
            MODE_CHECKER: pattern_c = (pixel_x[SQ_LOG] ^ pixel_y[SQ_LOG]) ? ~color_q : color_q;
            MODE_FADE:    pattern_c = {level_q, level_q, level_q};
            default:      pattern_c = color_q;
        endcase
    end

    // Blank outside the visible area
    always_comb begin
        rgb_d = video_on ? pattern_c : '0;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_pending_q <= '0;
            mode_active_q  <= '0;
            color_q        <= '0;
            level_q        <= '0;
            rgb_q          <= '0;
        end else begin
            mode_pending_q <= mode_pending_d;
            mode_active_q  <= mode_active_d;
            color_q        <= color_d;
            level_q        <= level_d;
            rgb_q          <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule
